// File: rtl/wr_req_adapter.sv
// Write-side front end of the async FIFO: buffers a valid/ready stream in a small queue
// and feeds wr_ctrl through an active-low request, with data aligned to its wr_en strobe.
module wr_req_adapter #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     wr_clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic [DATA_WIDTH-1:0]    s_data,
    output logic                     s_ready,
    input  logic                     full,
    input  logic                     wr_en,
    output logic                     wr_req_,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_WIDTH-1:0]     stall_cnt,
    output logic                     proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_head;
    logic [AW-1:0]         r_tail;
    logic [LW-1:0]         r_level;
    logic [CNT_WIDTH-1:0]  r_stallCnt;
    logic                  r_protoErr;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_wrReq;
    logic                  w_stall;
    logic [LW-1:0]         w_wrEnLevel;

    // The word under an active wr_en is already spoken for, so only request when
    // another word sits behind it; this gives back-to-back writes without duplicates.
    assign w_wrEnLevel = {{AW{1'b0}}, wr_en};
    assign w_wrReq     = (r_level > w_wrEnLevel);
    assign w_push      = s_valid && s_ready;
    assign w_pop       = wr_en && (r_level != '0);
    assign w_stall     = w_wrReq && full;

    assign s_ready   = (r_level != FULL_LEVEL);
    assign wr_req_   = !w_wrReq;
    assign wr_data   = r_mem[r_head];
    assign level     = r_level;
    assign stall_cnt = r_stallCnt;
    assign proto_err = r_protoErr;

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_tail] <= s_data;
        end
    end

    // Pointers wrap naturally; the separate level register keeps full and empty distinct.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            r_stallCnt <= '0;
            r_protoErr <= 1'b0;
        end else begin
            if (w_stall && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end
            if (wr_en && (r_level == '0)) begin
                r_protoErr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wr_req_adapter.sv
// Scoreboard bench for wr_req_adapter: a wr_ctrl model drives wr_en from wr_req_/full,
// and a negedge monitor compares each committed word against the expected queue.
module tb_wr_req_adapter;

    logic       clk;
    logic       rst;
    logic       sValid;
    logic [7:0] sData;
    logic       sReady;
    logic       full;
    logic       wrEn;
    logic       wrReqN;
    logic [7:0] wrData;
    logic [2:0] level;
    logic [3:0] stallCnt;
    logic       protoErr;

    logic       modelEnable;
    logic       modelWrEn;
    logic       forceEn;
    logic       expectProto;

    logic [7:0] sbQ[$];
    int         levelLog[$];
    int         checks;
    int         errors;
    int         commitCount;

    wr_req_adapter #(
        .DATA_WIDTH(8),
        .DEPTH     (4),
        .CNT_WIDTH (4)
    ) dut (
        .wr_clk   (clk),
        .rst      (rst),
        .s_valid  (sValid),
        .s_data   (sData),
        .s_ready  (sReady),
        .full     (full),
        .wr_en    (wrEn),
        .wr_req_  (wrReqN),
        .wr_data  (wrData),
        .level    (level),
        .stall_cnt(stallCnt),
        .proto_err(protoErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign wrEn = modelWrEn | forceEn;

    // wr_ctrl model: sample the request at one edge, strobe wr_en for the following cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            modelWrEn <= 1'b0;
        end else begin
            modelWrEn <= modelEnable && !wrReqN && !full;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Every cycle with wr_en high is a commit; it must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && wrEn && !expectProto) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedWrite actual=%0h required=none", wrData);
            end else begin
                commitCount++;
                checkOutput("wrData", int'(wrData), int'(sbQ.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] first, input int count, output int cycles);
        int  sent;
        logic accepted;
        sent   = 0;
        cycles = 0;
        while (sent < count && cycles < 64) begin
            sValid   = 1'b1;
            sData    = first + 8'(sent);
            accepted = sReady;
            if (accepted) sbQ.push_back(sData);
            tick();
            cycles++;
            levelLog.push_back(int'(level));
            if (accepted) sent++;
        end
        sValid = 1'b0;
        if (sent < count) begin
            checks++;
            errors++;
            $display("[TB] FAIL pushTimeout actual=%0d required=%0d", sent, count);
        end
    endtask

    task automatic resetDut();
        rst = 1'b1;
        sbQ.delete();
        modelEnable = 1'b0;
        full        = 1'b0;
        sValid      = 1'b0;
        forceEn     = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((sbQ.size() != 0 || level != 0) && n < 40) begin
            tick();
            n++;
        end
        checkOutput("drainLevel", int'(level), 0);
        checkOutput("drainPending", sbQ.size(), 0);
    endtask

    initial begin
        automatic int cycles;
        automatic int expLog[6] = '{4, 3, 3, 3, 3, 3};
        checks      = 0;
        errors      = 0;
        commitCount = 0;
        expectProto = 1'b0;
        sData       = 8'h00;
        rst         = 1'b1;
        modelEnable = 1'b0;
        full        = 1'b0;
        sValid      = 1'b0;
        forceEn     = 1'b0;
        #1;
        checkOutput("rstReqN", int'(wrReqN), 1);
        checkOutput("rstLevel", int'(level), 0);
        checkOutput("rstReady", int'(sReady), 1);
        checkOutput("rstStall", int'(stallCnt), 0);
        checkOutput("rstErr", int'(protoErr), 0);
        checkOutput("rstData", int'(wrData), 0);
        resetDut();

        $display("[TB] single word");
        modelEnable = 1'b1;
        commitCount = 0;
        applyStimulus(8'hA5, 1, cycles);
        checkOutput("singleLevelE", int'(level), 1);
        checkOutput("singleReqE", int'(wrReqN), 0);
        tick();
        checkOutput("singleWrEn", int'(wrEn), 1);
        checkOutput("singleNoDup", int'(wrReqN), 1);
        checkOutput("singleData", int'(wrData), 8'hA5);
        tick();
        checkOutput("singleLevelEnd", int'(level), 0);
        checkOutput("singleCommits", commitCount, 1);

        $display("[TB] streaming");
        commitCount = 0;
        applyStimulus(8'h01, 8, cycles);
        checkOutput("streamCycles", cycles, 8);
        waitDrain();
        checkOutput("streamCommits", commitCount, 8);
        checkOutput("streamStall", int'(stallCnt), 0);

        $display("[TB] reset mid-burst");
        modelEnable = 1'b0;
        applyStimulus(8'h61, 3, cycles);
        checkOutput("burstLevel", int'(level), 3);
        rst = 1'b1;
        sbQ.delete();
        #1;
        checkOutput("midRstReqN", int'(wrReqN), 1);
        checkOutput("midRstLevel", int'(level), 0);
        checkOutput("midRstReady", int'(sReady), 1);
        checkOutput("midRstStall", int'(stallCnt), 0);
        resetDut();

        $display("[TB] full stall");
        commitCount = 0;
        applyStimulus(8'h11, 4, cycles);
        checkOutput("stallLevel", int'(level), 4);
        checkOutput("stallReady", int'(sReady), 0);
        checkOutput("stallReqN", int'(wrReqN), 0);
        full        = 1'b1;
        modelEnable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("stallHoldData", int'(wrData), 8'h11);
            checkOutput("stallNoWrEn", int'(wrEn), 0);
        end
        checkOutput("stallCnt5", int'(stallCnt), 5);
        full = 1'b0;
        waitDrain();
        checkOutput("stallCommits", commitCount, 4);

        $display("[TB] simultaneous push/pop with wrap");
        resetDut();
        applyStimulus(8'h31, 3, cycles);
        checkOutput("simPreLevel", int'(level), 3);
        modelEnable = 1'b1;
        levelLog.delete();
        applyStimulus(8'h34, 5, cycles);
        checkOutput("simCycles", cycles, 6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("simLevel%0d", i), (i < levelLog.size()) ? levelLog[i] : -1, expLog[i]);
        end
        waitDrain();

        $display("[TB] protocol error");
        resetDut();
        expectProto = 1'b1;
        forceEn     = 1'b1;
        tick();
        forceEn = 1'b0;
        checkOutput("protoErr", int'(protoErr), 1);
        checkOutput("protoLevel", int'(level), 0);
        checkOutput("protoReqN", int'(wrReqN), 1);
        tick();
        expectProto = 1'b0;
        checkOutput("protoSticky", int'(protoErr), 1);

        $display("[TB] stall saturation");
        resetDut();
        applyStimulus(8'h5A, 1, cycles);
        full        = 1'b1;
        modelEnable = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        checkOutput("satStall", int'(stallCnt), 15);
        checkOutput("satLevel", int'(level), 1);
        checkOutput("satData", int'(wrData), 8'h5A);
        full = 1'b0;
        waitDrain();
        checkOutput("satHold", int'(stallCnt), 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
